video_dot_serializer: RTL and testbench
=======================================

VIDEO_DOT_SERIALIZER -- requirements
Module: video_dot_serializer

Interface
REQ-001 Parameter BLINK_FRAMES, default 16, sets the number of frame_start pulses per cursor blink phase.
REQ-002 clk  in  1  dot clock.
REQ-003 reset_n  in  1  reset, asynchronous, active-low.
REQ-004 dot_en  in  1  dot-clock enable; all state advances only when dot_en=1.
REQ-005 frame_start  in  1  single-dot pulse marking the start of a frame.
REQ-006 line_start  in  1  single-dot pulse marking the start of a visible scanline.
REQ-007 char_code  in  6  character code from screen RAM for col_addr, valid one enabled dot after col_addr changes.
REQ-008 cursor_flag  in  1  cursor marker for the character on char_code, same timing as char_code.
REQ-009 rom_a  out  9  character-generator address {char[5:0], scan[2:0]}, registered.
REQ-010 rom_x  in  5  character-generator glyph row; combinational response to rom_a; bit 5 is the leftmost dot.
REQ-011 col_addr  out  6  screen RAM column, 0..39.
REQ-012 row_addr  out  5  screen RAM text row, 0..23.
REQ-013 active  out  1  high while dot_out carries a visible cell.
REQ-014 dot_out  out  1  serial pixel.
REQ-015 line_done  out  1  single-dot pulse after the last cell of a line has shifted out.

Function
REQ-016 Cell = 7 enabled dots, numbered 0..6; dots 0..4 carry rom_x[5]..rom_x[1]; dots 5 and 6 are 0.
REQ-017 Fetch pipeline for column N: dot 0 drives col_addr=N; dot 1 registers rom_a={char_code or substitute, scan}; dot 6 loads rom_x into the shift register.
REQ-018 Shift-out of column N occurs during cell N+1; latency from col_addr=N to first dot is 7 enabled dots.
REQ-019 A line spans 41 cells: fetch in cells 0..39, drain in cell 40; col_addr holds 39 during cell 40.
REQ-020 active is high exactly during cells 1..40 of a line whose row_addr<24; dot_out is 0 whenever active=0.
REQ-021 The state machine has states IDLE, FETCH, DRAIN and DONE: IDLE->FETCH on line_start when row_addr<24; FETCH->DRAIN at the end of cell 39; DRAIN->DONE at the end of cell 40; DONE->IDLE after one dot, with line_done=1 during DONE.
REQ-022 On each line_done, scan increments 0..7; on a 7->0 wrap, row_addr increments; at row_addr=24 further line_start pulses are ignored until frame_start.
REQ-023 frame_start clears scan, row_addr, col_addr and the shift register, and returns the FSM to IDLE; it also advances the blink counter.
REQ-024 frame_start and line_start in the same enabled dot: frame_start wins and line_start is ignored.
REQ-025 line_start during FETCH/DRAIN restarts the line at cell 0, clears the shift register and leaves scan unchanged.
REQ-026 Blink counter counts frame_start modulo 2*BLINK_FRAMES; blink_on = (count < BLINK_FRAMES).
REQ-027 When cursor_flag=1 and blink_on=1, the rom_a char field is forced to 6'b000000 ('@'); otherwise it equals char_code.
REQ-028 dot_en=0 freezes every register, including outputs and pulses (a pulse remains asserted until the next enabled dot).

Reset
REQ-029 reset_n=0 asynchronously forces the FSM to IDLE and sets rom_a=0, col_addr=0, row_addr=0, scan=0, blink count=0, shift register=0, dot_out=0, active=0, line_done=0.
REQ-030 Reset assertion mid-line aborts the line immediately; after release, no output activity occurs until the next line_start.

Structure
REQ-031 The shared video package holds CELL_DOTS=7, GLYPH_DOTS=5, COLS=40, ROWS=24, SCANS=8, the cursor code 6'h00 and the FSM state enum.
REQ-032 The 5-bit parallel-load shift register is one sub-module, dot_shift_reg, with inputs load, shift and en.

Verification
REQ-033 dot_en=1, frame_start then line_start, char_code=6'h01 ('A') for all columns, rom model = character generator; scan 0 -> dot_out=0 for 280 dots; scan 1 -> pattern 0010000 per cell, first visible dot 7 dots after line_start+1.
REQ-034 Line timing: line_done pulses exactly 287 enabled dots after line_start; after 8 lines, row_addr=1 and scan=0; after 192 lines, further line_start pulses leave active low.
REQ-035 Cursor: cursor_flag=1 at col 5, char_code=6'h02, scan 1, frames 0..15 -> cell 6 shows 0111000 ('@'); frames 16..31 -> cell 6 shows 1111000 ('B').
REQ-036 frame_start and line_start in the same dot -> counters cleared, FSM stays IDLE, active=0; line_start issued mid-line at cell 20 -> col_addr returns to 0 and the line completes 41 cells later.
REQ-037 dot_en toggled 1/0 alternately -> dot_out sequence identical to the full-rate run, each dot held 2 clocks.
REQ-038 reset_n pulsed low at cell 12 -> all outputs 0 within the same clock, no line_done, normal operation on the next line_start.

Source files
------------

// File: rtl/video_dot_serializer_pkg.sv
// Shared constants and FSM state type for the character-cell video serializer.
package video_dot_serializer_pkg;

  localparam int unsigned CELL_DOTS  = 7;
  localparam int unsigned GLYPH_DOTS = 5;
  localparam int unsigned COLS       = 40;
  localparam int unsigned ROWS       = 24;
  localparam int unsigned SCANS      = 8;

  localparam logic [5:0] CURSOR_CODE = 6'h00;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StDrain,
    StDone
  } vid_state_e;

endpackage

// File: rtl/dot_shift_reg.sv
// Parallel-load glyph shift register; MSB is the dot currently on screen.
module dot_shift_reg
  import video_dot_serializer_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic                  clr,
  input  logic                  load,
  input  logic                  shift,
  input  logic [GLYPH_DOTS-1:0] din,
  output logic                  dout
);

  logic [GLYPH_DOTS-1:0] sr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr_q <= '0;
    end else if (en) begin
      if (clr) begin
        sr_q <= '0;
      end else if (load) begin
        sr_q <= din;
      end else if (shift) begin
        sr_q <= {sr_q[GLYPH_DOTS-2:0], 1'b0};
      end
    end
  end

  assign dout = sr_q[GLYPH_DOTS-1];

endmodule

// File: rtl/video_dot_serializer.sv
// Text-mode dot serializer: fetches 40 glyph rows per scanline and shifts them
// out one cell behind the fetch, with a blinking block-substitute cursor.
module video_dot_serializer
  import video_dot_serializer_pkg::*;
#(
  parameter int unsigned BLINK_FRAMES = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       dot_en,
  input  logic       frame_start,
  input  logic       line_start,
  input  logic [5:0] char_code,
  input  logic       cursor_flag,
  output logic [8:0] rom_a,
  input  logic [5:1] rom_x,
  output logic [5:0] col_addr,
  output logic [4:0] row_addr,
  output logic       active,
  output logic       dot_out,
  output logic       line_done
);

  localparam int unsigned BlinkW = $clog2(2 * BLINK_FRAMES);

  vid_state_e        state_q, state_d;
  logic [2:0]        dot_q, dot_d;
  logic [5:0]        cell_q, cell_d;
  logic [5:0]        col_q, col_d;
  logic [4:0]        row_q, row_d;
  logic [2:0]        scan_q, scan_d;
  logic [BlinkW-1:0] blink_q, blink_d;
  logic [8:0]        rom_a_q, rom_a_d;

  logic       sr_clr, sr_load, sr_msb;
  logic       line_go, blink_on, last_dot;
  logic [5:0] char_sel;

  assign line_go  = line_start && (row_q < 5'(ROWS));
  assign blink_on = blink_q < BlinkW'(BLINK_FRAMES);
  assign char_sel = (cursor_flag && blink_on) ? CURSOR_CODE : char_code;
  assign last_dot = dot_q == 3'(CELL_DOTS - 1);

  always_comb begin
    state_d = state_q;
    dot_d   = dot_q;
    cell_d  = cell_q;
    col_d   = col_q;
    row_d   = row_q;
    scan_d  = scan_q;
    blink_d = blink_q;
    rom_a_d = rom_a_q;
    sr_clr  = 1'b0;
    sr_load = 1'b0;

    if (frame_start) begin
      state_d = StIdle;
      dot_d   = '0;
      cell_d  = '0;
      col_d   = '0;
      row_d   = '0;
      scan_d  = '0;
      sr_clr  = 1'b1;
      blink_d = (blink_q == BlinkW'(2 * BLINK_FRAMES - 1)) ? '0 : blink_q + BlinkW'(1);
    end else if (line_go && state_q != StDone) begin
      // Start from idle, or restart a line already in progress.
      state_d = StFetch;
      dot_d   = '0;
      cell_d  = '0;
      col_d   = '0;
      sr_clr  = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
        end
        StFetch, StDrain: begin
          dot_d = dot_q + 3'd1;
          if (state_q == StFetch && dot_q == 3'd1) begin
            rom_a_d = {char_sel, scan_q};
          end
          if (last_dot) begin
            dot_d  = '0;
            cell_d = cell_q + 6'd1;
            if (state_q == StFetch) begin
              sr_load = 1'b1;
              // col_addr holds the last column through the drain cell.
              if (cell_q == 6'(COLS - 1)) begin
                state_d = StDrain;
              end else begin
                col_d = cell_q + 6'd1;
              end
            end else begin
              state_d = StDone;
            end
          end
        end
        StDone: begin
          state_d = StIdle;
          scan_d  = scan_q + 3'd1;
          if (scan_q == 3'(SCANS - 1)) begin
            row_d = row_q + 5'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      dot_q   <= '0;
      cell_q  <= '0;
      col_q   <= '0;
      row_q   <= '0;
      scan_q  <= '0;
      blink_q <= '0;
      rom_a_q <= '0;
    end else if (dot_en) begin
      state_q <= state_d;
      dot_q   <= dot_d;
      cell_q  <= cell_d;
      col_q   <= col_d;
      row_q   <= row_d;
      scan_q  <= scan_d;
      blink_q <= blink_d;
      rom_a_q <= rom_a_d;
    end
  end

  dot_shift_reg u_shift (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (dot_en),
    .clr     (sr_clr),
    .load    (sr_load),
    .shift   (1'b1),
    .din     (rom_x),
    .dout    (sr_msb)
  );

  assign rom_a     = rom_a_q;
  assign col_addr  = col_q;
  assign row_addr  = row_q;
  assign active    = (state_q == StFetch || state_q == StDrain) && (cell_q != 6'd0);
  assign dot_out   = active & sr_msb;
  assign line_done = state_q == StDone;

endmodule

// File: tb/tb_video_dot_serializer.sv
// Directed bench: screen RAM and character ROM models, expected dot stream queued per line.
module tb_video_dot_serializer;

  localparam int BF = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       dot_en = 1'b1;
  logic       half_rate = 1'b0;
  logic       frame_start = 1'b0;
  logic       line_start = 1'b0;
  logic [5:0] char_code = 6'h00;
  logic       cursor_flag = 1'b0;
  logic [8:0] rom_a;
  logic [5:1] rom_x;
  logic [5:0] col_addr;
  logic [4:0] row_addr;
  logic       active, dot_out, line_done;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;
  bit exp_q[$];
  int scan_m = 0;
  int row_m = 0;
  int blink_m = 0;
  logic [5:0] screen [64];
  logic [5:0] cursor_col = 6'd63;

  logic [4:0] g_at [8] = '{5'b00000, 5'b01110, 5'b10001, 5'b10111,
                           5'b10110, 5'b10000, 5'b01111, 5'b00000};
  logic [4:0] g_a  [8] = '{5'b00000, 5'b00100, 5'b01010, 5'b10001,
                           5'b11111, 5'b10001, 5'b10001, 5'b00000};
  logic [4:0] g_b  [8] = '{5'b00000, 5'b11110, 5'b10001, 5'b11110,
                           5'b10001, 5'b10001, 5'b11110, 5'b00000};

  video_dot_serializer #(.BLINK_FRAMES(BF)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .dot_en      (dot_en),
    .frame_start (frame_start),
    .line_start  (line_start),
    .char_code   (char_code),
    .cursor_flag (cursor_flag),
    .rom_a       (rom_a),
    .rom_x       (rom_x),
    .col_addr    (col_addr),
    .row_addr    (row_addr),
    .active      (active),
    .dot_out     (dot_out),
    .line_done   (line_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) dot_en <= half_rate ? ~dot_en : 1'b1;

  function automatic logic [4:0] glyph(input logic [5:0] ch, input logic [2:0] sc);
    case (ch)
      6'h00:   return g_at[sc];
      6'h01:   return g_a[sc];
      6'h02:   return g_b[sc];
      default: return 5'b00000;
    endcase
  endfunction

  always_comb rom_x = glyph(rom_a[8:3], rom_a[2:0]);

  // Screen RAM: data appears one enabled dot after the address.
  always @(posedge clk) begin
    if (dot_en) begin
      char_code   <= screen[col_addr];
      cursor_flag <= (col_addr == cursor_col);
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && reset_n && dot_en) begin
      if (active) begin
        if (exp_q.size() == 0) check("dot_extra", exp_q.size(), 1);
        else check("dot_out", int'(dot_out), int'(exp_q.pop_front()));
      end else begin
        check("dot_idle", int'(dot_out), 0);
      end
    end
  end

  task automatic push_line();
    logic [5:0] ch;
    logic [4:0] g;
    exp_q.delete();
    for (int c = 0; c < 40; c++) begin
      ch = screen[c];
      if (c == int'(cursor_col) && blink_m < BF) ch = 6'h00;
      g = glyph(ch, 3'(scan_m));
      for (int d = 0; d < 7; d++) exp_q.push_back(d < 5 ? g[4-d] : 1'b0);
    end
  endtask

  task automatic wait_en_negedge();
    @(negedge clk);
    while (!dot_en) @(negedge clk);
  endtask

  task automatic wait_en(input int n);
    int i = 0;
    bit en_prev;
    while (i < n) begin
      en_prev = dot_en;
      @(negedge clk);
      if (en_prev) i++;
    end
  endtask

  task automatic pulse_line();
    wait_en_negedge();
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
  endtask

  task automatic pulse_frame(input bit with_line);
    wait_en_negedge();
    frame_start = 1'b1;
    line_start  = with_line;
    @(negedge clk);
    frame_start = 1'b0;
    line_start  = 1'b0;
    blink_m = (blink_m + 1) % (2 * BF);
    scan_m = 0;
    row_m = 0;
  endtask

  // Counts enabled edges from the line_start edge to line_done and first active dot.
  task automatic measure(input bit expect_run);
    int k = 0;
    int first_act = -1;
    int cyc = 0;
    bit seen_done = 1'b0;
    bit en_prev;
    while (cyc < 1500 && !seen_done) begin
      en_prev = dot_en;
      @(negedge clk);
      cyc++;
      if (en_prev) k++;
      if (active && first_act < 0) first_act = k;
      if (line_done) seen_done = 1'b1;
    end
    if (expect_run) begin
      check("line_done_seen", int'(seen_done), 1);
      check("line_done_latency", k, 287);
      check("first_visible_dot", first_act, 7);
      do begin
        en_prev = dot_en;
        @(negedge clk);
      end while (!en_prev);
      check("line_done_width", int'(line_done), 0);
      check("dots_drained", exp_q.size(), 0);
      scan_m = (scan_m + 1) % 8;
      if (scan_m == 0) row_m++;
      check("row_addr", int'(row_addr), row_m);
    end else begin
      check("ignored_active", first_act, -1);
      check("ignored_done", int'(seen_done), 0);
    end
  endtask

  task automatic run_line(input bit expect_run);
    if (expect_run) push_line();
    pulse_line();
    measure(expect_run);
  endtask

  task automatic check_reset_outputs();
    check("rst_rom_a", int'(rom_a), 0);
    check("rst_col_addr", int'(col_addr), 0);
    check("rst_row_addr", int'(row_addr), 0);
    check("rst_active", int'(active), 0);
    check("rst_dot_out", int'(dot_out), 0);
    check("rst_line_done", int'(line_done), 0);
  endtask

  initial begin
    int act_cnt;
    for (int c = 0; c < 64; c++) screen[c] = 6'h01;

    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_reset_outputs();
    @(negedge clk);
    reset_n = 1'b1;

    // Full-rate 'A' lines through the whole frame.
    pulse_frame(1'b0);
    chk_en = 1'b1;
    repeat (8) run_line(1'b1);
    check("row_after_8_lines", int'(row_addr), 1);
    repeat (184) run_line(1'b1);
    check("row_at_end", int'(row_addr), 24);
    run_line(1'b0);

    // Cursor on column 5 over 'B' cells, both blink phases.
    pulse_frame(1'b0);
    for (int c = 0; c < 64; c++) screen[c] = 6'h02;
    cursor_col = 6'd5;
    run_line(1'b1);
    run_line(1'b1);
    while (blink_m != BF) pulse_frame(1'b0);
    run_line(1'b1);
    run_line(1'b1);

    // frame_start and line_start in the same dot.
    for (int c = 0; c < 64; c++) screen[c] = 6'h01;
    cursor_col = 6'd63;
    run_line(1'b1);
    pulse_frame(1'b1);
    act_cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (active || line_done) act_cnt++;
    end
    check("both_idle", act_cnt, 0);
    check("both_col", int'(col_addr), 0);
    check("both_row", int'(row_addr), 0);
    run_line(1'b1);
    check("rom_a_after_clear", int'(rom_a), int'({6'h01, 3'd0}));

    // Restart mid-line at cell 20.
    chk_en = 1'b0;
    pulse_line();
    wait_en(140);
    push_line();
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
    chk_en = 1'b1;
    check("restart_col", int'(col_addr), 0);
    measure(1'b1);

    // Half-rate dot enable.
    half_rate = 1'b1;
    run_line(1'b1);
    half_rate = 1'b0;

    // Reset mid-line at cell 12.
    chk_en = 1'b0;
    pulse_line();
    wait_en(84);
    reset_n = 1'b0;
    #1;
    check_reset_outputs();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    scan_m = 0;
    row_m = 0;
    blink_m = 0;
    act_cnt = 0;
    repeat (50) begin
      @(negedge clk);
      if (active || line_done) act_cnt++;
    end
    check("post_reset_quiet", act_cnt, 0);
    chk_en = 1'b1;
    run_line(1'b1);
    run_line(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
